// File: rtl/decoder_select_arbiter.sv
// decoder_select_arbiter
//
// Round-robin arbiter and sequencer that shares one 3-to-8 decoder among
// NREQ requesters. A winner is picked, its 3-bit target address is latched
// onto dec_a, and after one settle cycle dec_en is held high for
// HOLD_CYCLES cycles. One guard cycle then follows with enable and grant low.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   req       in   [NREQ-1:0]   level request per requester
//   sel_addr  in   [3*NREQ-1:0] packed target addresses, requester i at [3*i+2:3*i]
//   dec_a     out  [2:0]        decoder address (registered, held in IDLE)
//   dec_en    out               decoder enable (registered, high only in ACTIVE)
//   grant     out  [NREQ-1:0]   one-hot current owner (registered)
//   done      out  [NREQ-1:0]   one-cycle pulse to the owner when its window closes
//   busy      out               high in SETUP, ACTIVE and RELEASE
//   dbg_state out  [1:0]        current FSM state (0 IDLE, 1 SETUP, 2 ACTIVE, 3 RELEASE)
//
// Request/grant protocol: req is a level. It is sampled only in IDLE and
// RELEASE. A winner sees grant one-hot from SETUP through the last ACTIVE
// cycle, then a single done pulse in RELEASE (grant is low on that cycle).
// The requester is expected to drop req after done; a req still high in
// RELEASE competes again at lowest priority. Dropping req or changing
// sel_addr while granted has no effect on the window in progress.

module decoder_select_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] sel_addr,
    output logic [2:0]        dec_a,
    output logic              dec_en,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = $clog2(HOLD_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        dec_a_q, dec_a_d;
    logic              dec_en_q, dec_en_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Arbitration result, valid whenever any req bit is high.
    logic              win_found;
    logic [IDXW-1:0]   win_idx;
    logic [NREQ-1:0]   win_onehot;
    logic [2:0]        win_addr;

    // Round-robin search starting one past the last winner. Offset NREQ
    // wraps back to the last winner itself, so it is only re-granted when
    // nobody else is asking.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_found && req[(int'(last_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = IDXW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    assign win_onehot = NREQ'(1) << win_idx;
    assign win_addr   = sel_addr[3*int'(win_idx) +: 3];

    always_comb begin
        state_d  = state_q;
        dec_a_d  = dec_a_q;
        dec_en_d = 1'b0;
        grant_d  = grant_q;
        done_d   = '0;
        last_d   = last_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE, RELEASE: begin
                if (win_found) begin
                    state_d = SETUP;
                    grant_d = win_onehot;
                    dec_a_d = win_addr;
                    last_d  = win_idx;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            SETUP: begin
                state_d  = ACTIVE;
                dec_en_d = 1'b1;
                cnt_d    = CW'(HOLD_CYCLES - 1);
            end
            ACTIVE: begin
                if (cnt_q == '0) begin
                    // Window closes: hand the owner its done pulse and
                    // clear the grant in the same guard cycle.
                    state_d = RELEASE;
                    grant_d = '0;
                    done_d  = grant_q;
                end else begin
                    dec_en_d = 1'b1;
                    cnt_d    = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            dec_a_q  <= '0;
            dec_en_q <= 1'b0;
            grant_q  <= '0;
            done_q   <= '0;
            last_q   <= IDXW'(NREQ - 1);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dec_a_q  <= dec_a_d;
            dec_en_q <= dec_en_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dec_a     = dec_a_q;
    assign dec_en    = dec_en_q;
    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_decoder_select_arbiter.sv
// Directed testbench for decoder_select_arbiter (NREQ=4, HOLD_CYCLES=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there.

module tb_decoder_select_arbiter;

    localparam int NREQ = 4;
    localparam int HOLD = 4;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] sel_addr;
    logic [2:0]        dec_a;
    logic              dec_en;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [1:0]        dbg_state;

    int checks   = 0;
    int failures = 0;

    decoder_select_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .sel_addr  (sel_addr),
        .dec_a     (dec_a),
        .dec_en    (dec_en),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
    endtask

    // Reset state
    task automatic test_reset();
        sel_addr = 12'hFFF;
        do_reset();
        checks++; if (dec_en !== 1'b0) begin failures++; $display("FAIL reset_dec_en got=%b exp=0", dec_en); end
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (dec_a !== 3'd0) begin failures++; $display("FAIL reset_dec_a got=%0d exp=0", dec_a); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        // Idle with no request stays idle
        tick();
        checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin failures++; $display("FAIL reset_idle busy=%b grant=%b exp busy=0 grant=0000", busy, grant); end
    endtask

    // Single request: grant at E1, enable E2..E5, done E6, idle E7
    task automatic test_single();
        do_reset();
        req      = 4'b0001;
        sel_addr = 12'h005;
        tick(); // E1
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", grant); end
        checks++; if (dec_a !== 3'd5) begin failures++; $display("FAIL single_dec_a got=%0d exp=5", dec_a); end
        checks++; if (dec_en !== 1'b0 || busy !== 1'b1 || dbg_state !== 2'd1) begin failures++; $display("FAIL single_setup en=%b busy=%b st=%0d exp en=0 busy=1 st=1", dec_en, busy, dbg_state); end
        for (int c = 0; c < HOLD; c++) begin
            tick(); // E2..E5
            checks++; if (dec_en !== 1'b1 || grant !== 4'b0001 || dbg_state !== 2'd2) begin failures++; $display("FAIL single_active cyc=%0d en=%b grant=%b st=%0d exp en=1 grant=0001 st=2", c, dec_en, grant, dbg_state); end
        end
        tick(); // E6
        checks++; if (done !== 4'b0001) begin failures++; $display("FAIL single_done got=%b exp=0001", done); end
        checks++; if (dec_en !== 1'b0 || grant !== 4'b0000 || dbg_state !== 2'd3) begin failures++; $display("FAIL single_release en=%b grant=%b st=%0d exp en=0 grant=0000 st=3", dec_en, grant, dbg_state); end
        req = 4'b0000;
        tick(); // E7
        checks++; if (busy !== 1'b0 || done !== 4'b0000 || dbg_state !== 2'd0) begin failures++; $display("FAIL single_idle busy=%b done=%b st=%0d exp busy=0 done=0000 st=0", busy, done, dbg_state); end
        checks++; if (dec_a !== 3'd5) begin failures++; $display("FAIL single_hold_addr got=%0d exp=5", dec_a); end
    endtask

    // Contention between requesters 1 and 2
    task automatic test_contention();
        logic [NREQ-1:0] exp_g [3];
        logic [2:0]      exp_a [3];
        exp_g = '{4'b0010, 4'b0100, 4'b0010};
        exp_a = '{3'd2, 3'd4, 3'd2};
        do_reset();
        sel_addr = {3'd0, 3'd4, 3'd2, 3'd0};
        req      = 4'b0110;
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < HOLD + 2; c++) begin
                tick();
                if (c == 0) begin
                    checks++; if (grant !== exp_g[g] || dec_a !== exp_a[g]) begin failures++; $display("FAIL cont_grant win=%0d grant=%b dec_a=%0d exp grant=%b dec_a=%0d", g, grant, dec_a, exp_g[g], exp_a[g]); end
                    checks++; if (dec_en !== 1'b0 || done !== 4'b0000) begin failures++; $display("FAIL cont_setup win=%0d en=%b done=%b exp en=0 done=0000", g, dec_en, done); end
                end else if (c <= HOLD) begin
                    checks++; if (dec_en !== 1'b1 || grant !== exp_g[g]) begin failures++; $display("FAIL cont_active win=%0d cyc=%0d en=%b grant=%b exp en=1 grant=%b", g, c, dec_en, grant, exp_g[g]); end
                end else begin
                    checks++; if (dec_en !== 1'b0 || grant !== 4'b0000 || done !== exp_g[g]) begin failures++; $display("FAIL cont_release win=%0d en=%b grant=%b done=%b exp en=0 grant=0000 done=%b", g, dec_en, grant, done, exp_g[g]); end
                end
            end
        end
    endtask

    // All four requesting: strict rotation 0,1,2,3,0
    task automatic test_full_load();
        logic [2:0] addr_tbl [4];
        int         order [5];
        addr_tbl = '{3'd0, 3'd3, 3'd6, 3'd7};
        order    = '{0, 1, 2, 3, 0};
        do_reset();
        sel_addr = {3'd7, 3'd6, 3'd3, 3'd0};
        req      = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < HOLD + 2; c++) begin
                tick();
                if (c == 0) begin
                    checks++; if (grant !== (4'b0001 << order[g]) || dec_a !== addr_tbl[order[g]]) begin failures++; $display("FAIL full_grant win=%0d grant=%b dec_a=%0d exp grant=%b dec_a=%0d", g, grant, dec_a, 4'b0001 << order[g], addr_tbl[order[g]]); end
                    checks++; if (dec_en !== 1'b0) begin failures++; $display("FAIL full_setup_en win=%0d got=%b exp=0", g, dec_en); end
                end else if (c <= HOLD) begin
                    checks++; if (dec_en !== 1'b1) begin failures++; $display("FAIL full_active_en win=%0d cyc=%0d got=%b exp=1", g, c, dec_en); end
                end else begin
                    checks++; if (dec_en !== 1'b0 || done !== (4'b0001 << order[g])) begin failures++; $display("FAIL full_release win=%0d en=%b done=%b exp en=0 done=%b", g, dec_en, done, 4'b0001 << order[g]); end
                end
            end
        end
    endtask

    // Reset during the second ACTIVE cycle aborts the window
    task automatic test_reset_mid_window();
        do_reset();
        sel_addr = {3'd7, 3'd6, 3'd3, 3'd1};
        req      = 4'b1111;
        tick(); // SETUP, owner 0
        tick(); // ACTIVE cycle 1
        tick(); // ACTIVE cycle 2
        checks++; if (dec_en !== 1'b1 || grant !== 4'b0001) begin failures++; $display("FAIL rstmid_pre en=%b grant=%b exp en=1 grant=0001", dec_en, grant); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (dec_en !== 1'b0 || grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_abort en=%b grant=%b done=%b busy=%b exp 0/0000/0000/0", dec_en, grant, done, busy); end
        tick();
        // Priority pointer was reset, so requester 0 wins again, not 1
        checks++; if (grant !== 4'b0001 || dec_a !== 3'd1) begin failures++; $display("FAIL rstmid_regrant grant=%b dec_a=%0d exp grant=0001 dec_a=1", grant, dec_a); end
        tick();
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL rstmid_no_done got=%b exp=0000", done); end
    endtask

    // sel_addr change and req drop during ACTIVE do not affect the window
    task automatic test_addr_change();
        do_reset();
        sel_addr = 12'h003;
        req      = 4'b0001;
        tick(); // E1
        checks++; if (grant !== 4'b0001 || dec_a !== 3'd3) begin failures++; $display("FAIL chg_grant grant=%b dec_a=%0d exp grant=0001 dec_a=3", grant, dec_a); end
        tick(); // E2, first ACTIVE cycle
        sel_addr = 12'h006;
        req      = 4'b0000;
        checks++; if (dec_en !== 1'b1) begin failures++; $display("FAIL chg_active0 en=%b exp=1", dec_en); end
        for (int c = 1; c < HOLD; c++) begin
            tick();
            checks++; if (dec_en !== 1'b1 || dec_a !== 3'd3) begin failures++; $display("FAIL chg_active cyc=%0d en=%b dec_a=%0d exp en=1 dec_a=3", c, dec_en, dec_a); end
        end
        tick(); // E6
        checks++; if (done !== 4'b0001 || dec_en !== 1'b0) begin failures++; $display("FAIL chg_done done=%b en=%b exp done=0001 en=0", done, dec_en); end
        tick(); // E7
        checks++; if (busy !== 1'b0 || dec_a !== 3'd3) begin failures++; $display("FAIL chg_idle busy=%b dec_a=%0d exp busy=0 dec_a=3", busy, dec_a); end
    endtask

    // Requester 0 holds req through RELEASE and is re-granted directly
    task automatic test_back_to_back();
        int low_cnt;
        do_reset();
        sel_addr = 12'h001;
        req      = 4'b0001;
        tick(); // E1
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL b2b_grant1 got=%b exp=0001", grant); end
        for (int c = 0; c < HOLD; c++) tick(); // E2..E5
        checks++; if (dec_en !== 1'b1) begin failures++; $display("FAIL b2b_last_active en=%b exp=1", dec_en); end
        low_cnt = 0;
        tick(); // E6 RELEASE
        if (dec_en === 1'b0) low_cnt++;
        checks++; if (done !== 4'b0001 || grant !== 4'b0000) begin failures++; $display("FAIL b2b_release done=%b grant=%b exp done=0001 grant=0000", done, grant); end
        tick(); // E7 SETUP again
        if (dec_en === 1'b0) low_cnt++;
        checks++; if (grant !== 4'b0001 || dbg_state !== 2'd1 || done !== 4'b0000) begin failures++; $display("FAIL b2b_regrant grant=%b st=%0d done=%b exp grant=0001 st=1 done=0000", grant, dbg_state, done); end
        tick(); // E8 ACTIVE
        checks++; if (dec_en !== 1'b1 || low_cnt != 2) begin failures++; $display("FAIL b2b_gap en=%b low_cycles=%0d exp en=1 low_cycles=2", dec_en, low_cnt); end
        req = 4'b0000;
        do_reset();
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        sel_addr = '0;
        test_reset();
        test_single();
        test_contention();
        test_full_load();
        test_reset_mid_window();
        test_addr_change();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
